// File: rtl/down_timer_pkg.sv
// ============================================================================
//  Module   : down_timer_pkg
//  Brief    : Shared types and constants for the loadable down-counting timer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package down_timer_pkg;

  // Default counter width; the maximum load at this width is 31.
  localparam int DOWN_TIMER_WIDTH_DEFAULT = 5;

  // Timer state encoding, explicitly two bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } down_timer_state_t;

endpackage : down_timer_pkg

`default_nettype wire

// File: rtl/down_timer.sv
// ============================================================================
//  Module   : down_timer
//  Brief    : Loadable down-counting timer with load/busy/done handshake,
//             pause via enable and abort. A load arms the timer; each enabled
//             cycle in RUN decrements the count and a one-cycle done pulse is
//             raised when the count reaches zero.
//  Options  : DOWN_TIMER_AUTO_RELOAD_EN - when defined, DONE re-enters RUN
//             with the last loaded value (periodic done). When undefined,
//             DONE always returns to IDLE and no reload register exists.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DOWN_TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  down_timer_state_t state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0]  reload_q, reload_d;
`endif

  // State, count and (optional) reload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      count_q  <= C_ZERO;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= C_ZERO;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Next-state / next-count: abort beats load, load beats the countdown.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (abort) begin
      state_d = IDLE;
      count_d = C_ZERO;
    end else if (load) begin
      count_d = load_val;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      // A zero load has nothing to count, so it terminates immediately.
      state_d = (load_val != C_ZERO) ? RUN : DONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (enable) begin
            if (count_q == C_ONE) begin
              count_d = C_ZERO;
              state_d = DONE;
            end else if (count_q != C_ZERO) begin
              count_d = count_q - C_ONE;
            end else begin
              // Unreachable in normal operation; never wrap below zero.
              count_d = C_ZERO;
              state_d = DONE;
            end
          end
        end
        DONE: begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          if (reload_q != C_ZERO) begin
            state_d = RUN;
            count_d = reload_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
          count_d = C_ZERO;
        end
      endcase
    end
  end

  // Outputs are decodes of registered state only: no input-to-output path.
  always_comb begin
    count = count_q;
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
  end

endmodule : down_timer

`default_nettype wire

// File: tb/tb_down_timer.sv
// ============================================================================
//  Module   : tb_down_timer
//  Brief    : Scoreboard bench for down_timer. The driver applies one vector
//             per cycle and queues the outputs expected after the next rising
//             edge; an independent monitor compares them on falling edges.
//  Options  : DOWN_TIMER_AUTO_RELOAD_EN selects the periodic expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_timer;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int W = 5;

  logic         clk;
  logic         rstn;
  logic         load;
  logic [W-1:0] load_val;
  logic         enable;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  down_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_val (load_val),
    .enable   (enable),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] c;
    logic         b;
    logic         d;
    string        name;
  } exp_t;

  exp_t q_exp[$];
  int   cyc_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation that has become due by this cycle.
  always @(negedge clk) begin
    while (q_exp.size() > 0 && q_exp[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q_exp.pop_front();
      n_checks++;
      if (count !== e.c || busy !== e.b || done !== e.d) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
                 e.name, cyc_cnt, count, busy, done, e.c, e.b, e.d);
      end
    end
  end

  // Drive one vector and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic ld, input int v, input logic en,
                      input logic ab, input int ec, input logic eb, input logic ed,
                      input string nm);
    exp_t e;
    rstn     = r;
    load     = ld;
    load_val = W'(v);
    enable   = en;
    abort    = ab;
    e.cyc  = cyc_cnt + 1;
    e.c    = W'(ec);
    e.b    = eb;
    e.d    = ed;
    e.name = nm;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int ec, input logic eb, input logic ed, input string nm);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0, ec, eb, ed, nm);
  endtask

  // After a DONE cycle: periodic builds re-enter RUN with the reload value.
  task automatic after_done(input int reload, input string nm);
    if (AR && reload != 0) run(reload, 1'b1, 1'b0, nm);
    else                   run(0, 1'b0, 1'b0, nm);
  endtask

  task automatic do_abort(input string nm);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, nm);
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0; abort = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "reset");

    // Basic countdown of 5
    step(1'b1, 1'b1, 5, 1'b1, 1'b0, 5, 1'b1, 1'b0, "basic_load");
    run(4, 1'b1, 1'b0, "basic_4");
    run(3, 1'b1, 1'b0, "basic_3");
    run(2, 1'b1, 1'b0, "basic_2");
    run(1, 1'b1, 1'b0, "basic_1");
    run(0, 1'b0, 1'b1, "basic_done");
    after_done(5, "basic_after");
    do_abort("basic_abort");
    run(0, 1'b0, 1'b0, "idle_enable_hold");

    // Pause: enable low for two cycles delays done by two
    step(1'b1, 1'b1, 4, 1'b1, 1'b0, 4, 1'b1, 1'b0, "pause_load");
    run(3, 1'b1, 1'b0, "pause_3");
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0, "pause_hold_a");
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0, "pause_hold_b");
    run(2, 1'b1, 1'b0, "pause_2");
    run(1, 1'b1, 1'b0, "pause_1");
    run(0, 1'b0, 1'b1, "pause_done");
    after_done(4, "pause_after");
    do_abort("pause_abort");

    // Zero load: done immediately, never busy
    step(1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, "zero_done");
    run(0, 1'b0, 1'b0, "zero_after");

    // Load accepted while in DONE
    step(1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, "zero_done2");
    step(1'b1, 1'b1, 2, 1'b1, 1'b0, 2, 1'b1, 1'b0, "load_in_done");

    // Abort beats load during RUN
    step(1'b1, 1'b1, 9, 1'b1, 1'b1, 0, 1'b0, 1'b0, "abort_vs_load");
    run(0, 1'b0, 1'b0, "abort_idle");

    // Restart during RUN at count 2
    step(1'b1, 1'b1, 6, 1'b1, 1'b0, 6, 1'b1, 1'b0, "restart_load6");
    run(5, 1'b1, 1'b0, "restart_5");
    run(4, 1'b1, 1'b0, "restart_4");
    run(3, 1'b1, 1'b0, "restart_3");
    run(2, 1'b1, 1'b0, "restart_2");
    step(1'b1, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b0, "restart_load3");
    run(2, 1'b1, 1'b0, "restart_b2");
    run(1, 1'b1, 1'b0, "restart_b1");
    run(0, 1'b0, 1'b1, "restart_done");
    after_done(3, "restart_after");
    do_abort("restart_abort");

    // Boundary: maximum load of 31, no wrap
    step(1'b1, 1'b1, 31, 1'b1, 1'b0, 31, 1'b1, 1'b0, "max_load");
    for (int i = 1; i <= 30; i++) run(31 - i, 1'b1, 1'b0, "max_count");
    run(0, 1'b0, 1'b1, "max_done");
    after_done(31, "max_after");
    do_abort("max_abort");
    run(0, 1'b0, 1'b0, "max_nowrap");

    // Reset mid-RUN at count 7 overrides load
    step(1'b1, 1'b1, 10, 1'b1, 1'b0, 10, 1'b1, 1'b0, "rst_load");
    run(9, 1'b1, 1'b0, "rst_9");
    run(8, 1'b1, 1'b0, "rst_8");
    run(7, 1'b1, 1'b0, "rst_7");
    step(1'b0, 1'b1, 12, 1'b1, 1'b0, 0, 1'b0, 1'b0, "rst_mid_a");
    step(1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "rst_mid_b");
    run(0, 1'b0, 1'b0, "rst_release");

    // Periodic operation (reload build) or single shot (default build)
    step(1'b1, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b0, "period_load");
    for (int k = 1; k < 12; k++) begin
      if (!AR && k >= 4)   run(0, 1'b0, 1'b0, "period_idle");
      else if (k % 4 == 0) run(3, 1'b1, 1'b0, "period_reload");
      else if (k % 4 == 3) run(0, 1'b0, 1'b1, "period_done");
      else                 run(3 - (k % 4), 1'b1, 1'b0, "period_count");
    end
    do_abort("period_abort");
    for (int k = 0; k < 5; k++) run(0, 1'b0, 1'b0, "period_stopped");

    // Let the monitor drain, then confirm nothing is left unchecked.
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_down_timer

`default_nettype wire
